key_cmd_scheduler: RTL

Turns the raw PS/2 byte stream from the keyboard interface into de-duplicated Tetris game commands with hardware auto-repeat. Commands are queued in a small FIFO, and the processor or VGA game logic drains them through a valid/ready handshake. The block sits between the PS/2 interface byte strobe and the game consumer. It sequences make/break prefix decoding, held-key tracking and repeat timing.

---
 rtl/key_cmd_pkg.sv | 44 ++++
 rtl/cmd_fifo.sv | 59 +++++
 rtl/key_cmd_scheduler.sv | 128 ++++++++++++
 3 files changed

// File: rtl/key_cmd_pkg.sv
// Shared encodings for the keyboard-to-command scheduler: command codes,
// PS/2 scan codes, decoder states and the scan-code lookup.
package key_cmd_pkg;

  localparam logic [2:0] CMD_NONE      = 3'd0;
  localparam logic [2:0] CMD_LEFT      = 3'd1;
  localparam logic [2:0] CMD_RIGHT     = 3'd2;
  localparam logic [2:0] CMD_ROTATE    = 3'd3;
  localparam logic [2:0] CMD_SOFT_DROP = 3'd4;
  localparam logic [2:0] CMD_HARD_DROP = 3'd5;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_SPACE = 8'h29;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} dec_state_t;

  // Arrows only count when E0-prefixed; space only counts unprefixed.
  function automatic logic [2:0] scan_to_cmd(input logic [7:0] code, input logic ext);
    logic [2:0] c;
    c = CMD_NONE;
    if (ext) begin
      case (code)
        SC_LEFT:  c = CMD_LEFT;
        SC_RIGHT: c = CMD_RIGHT;
        SC_UP:    c = CMD_ROTATE;
        SC_DOWN:  c = CMD_SOFT_DROP;
        default:  c = CMD_NONE;
      endcase
    end else if (code == SC_SPACE) begin
      c = CMD_HARD_DROP;
    end
    return c;
  endfunction

  function automatic logic is_repeatable(input logic [2:0] c);
    return (c == CMD_LEFT) || (c == CMD_RIGHT) || (c == CMD_SOFT_DROP);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small command queue with a registered head word and registered empty flag.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr, wr_next, rd_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] head_next;
  logic             pop_acc, push_acc;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_acc  = pop && !empty;
  assign push_acc = push && (!full || pop_acc);
  assign wr_next  = wr_ptr + {{AW{1'b0}}, push_acc};
  assign rd_next  = rd_ptr + {{AW{1'b0}}, pop_acc};

  // A word written this cycle into the slot that becomes head must bypass mem.
  always_comb begin
    head_next = '0;
    if (wr_next != rd_next) begin
      if (push_acc && (wr_ptr[AW-1:0] == rd_next[AW-1:0]))
        head_next = push_data;
      else
        head_next = mem[rd_next[AW-1:0]];
    end
  end

  always_ff @(posedge clock) begin
    if (push_acc)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      head   <= head_next;
      empty  <= (wr_next == rd_next);
    end
  end

endmodule

// File: rtl/key_cmd_scheduler.sv
// Decodes PS/2 make/break sequences into Tetris commands, tracks held keys,
// generates auto-repeat and queues everything for a valid/ready consumer.
module key_cmd_scheduler
  import key_cmd_pkg::*;
#(
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_en,
  input  logic [7:0] key_in,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  input  logic       cmd_ready,
  output logic [4:0] held,
  output logic       overflow
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] DELAY_LOAD = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LOAD  = CW'(REPEAT_RATE - 1);

  dec_state_t    state;
  logic          dec_fire, is_ext, is_brk;
  logic [2:0]    key_cmd, rep_key, push_data;
  logic [4:0]    key_mask;
  logic [CW-1:0] cnt;
  logic          make_new, brk_held, rep_req, push, pop, fifo_full, fifo_empty;

  always_comb begin
    dec_fire = 1'b0;
    is_ext   = 1'b0;
    is_brk   = 1'b0;
    if (key_en) begin
      case (state)
        IDLE:    dec_fire = (key_in != SC_E0) && (key_in != SC_F0);
        EXT: begin
          dec_fire = (key_in != SC_F0);
          is_ext   = 1'b1;
        end
        BRK: begin
          dec_fire = 1'b1;
          is_brk   = 1'b1;
        end
        default: begin
          dec_fire = 1'b1;
          is_ext   = 1'b1;
          is_brk   = 1'b1;
        end
      endcase
    end
  end

  assign key_cmd  = scan_to_cmd(key_in, is_ext);
  assign key_mask = (key_cmd == CMD_NONE) ? 5'b0 : (5'b1 << (key_cmd - 3'd1));
  assign make_new = dec_fire && !is_brk && (key_cmd != CMD_NONE) && ((held & key_mask) == 5'b0);
  assign brk_held = dec_fire && is_brk && (key_cmd != CMD_NONE) && ((held & key_mask) != 5'b0);
  assign rep_req  = (rep_key != CMD_NONE) && (cnt == '0);

  // A fresh press wins the single push slot; the repeat waits one cycle.
  assign push      = make_new || rep_req;
  assign push_data = make_new ? key_cmd : rep_key;
  assign cmd_valid = !fifo_empty;
  assign pop       = cmd_valid && cmd_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      held     <= '0;
      rep_key  <= CMD_NONE;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (key_en) begin
        case (state)
          IDLE: begin
            if (key_in == SC_E0)      state <= EXT;
            else if (key_in == SC_F0) state <= BRK;
          end
          EXT:     state <= (key_in == SC_F0) ? EXT_BRK : IDLE;
          default: state <= IDLE;
        endcase
      end

      if (rep_key != CMD_NONE) begin
        if (cnt != '0)     cnt <= cnt - CW'(1);
        else if (!make_new) cnt <= RATE_LOAD;
      end

      if (make_new) begin
        held <= held | key_mask;
        if (is_repeatable(key_cmd)) begin
          rep_key <= key_cmd;
          cnt     <= DELAY_LOAD;
        end
      end

      if (brk_held) begin
        held <= held & ~key_mask;
        if (key_cmd == rep_key) begin
          rep_key <= CMD_NONE;
          cnt     <= '0;
        end
      end

      if (push && fifo_full && !pop)
        overflow <= 1'b1;
    end
  end

  cmd_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(3)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (cmd),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule
